// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: bus widths, FSM state
// encoding, owner encoding and the latched memory command payload.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Command latched on the grant edge and driven to memory during ACCESS
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              mis;
  } cmd_t;

  // Word-aligned form of a byte address
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-requester winner select for the memory arbiter.
// Ports:
//   last_i   owner of the previous grant (only with MEM_ARB_RR_EN)
//   f_req_i  eligible fetch request
//   d_req_i  eligible data request
//   valid_c  some requester is eligible (combinational)
//   owner_c  winning port (combinational)
// MEM_ARB_RR_EN defined: round-robin on contention; otherwise data always wins.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  owner_e last_i,
`endif
  input  logic   f_req_i,
  input  logic   d_req_i,
  output logic   valid_c,
  output owner_e owner_c
);

  // Winner select; a lone requester always wins
  always_comb begin
    valid_c = f_req_i | d_req_i;
    owner_c = OWN_D;
    if (f_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      owner_c = (last_i == OWN_D) ? OWN_F : OWN_D;
`else
      owner_c = OWN_D;
`endif
    end else if (f_req_i) begin
      owner_c = OWN_F;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared byte-addressed program/data
// memory. One word access at a time: grant in IDLE or ACK, one-cycle memory
// command in ACCESS, one-cycle acknowledge to the owner in ACK.
// Ports:
//   clock, reset_n                   clock, async active-low reset
//   f_req/f_addr -> f_ack/f_rdata/f_err             fetch port (read-only)
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata/d_err data port
//   addrm/wmdata/re/we/mem_alu, rwdata              memory side
//   busy                             FSM not in IDLE
// Build option: MEM_ARB_RR_EN selects round-robin arbitration on contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] addrm,
  output logic [DATA_W-1:0] wmdata,
  output logic              re,
  output logic              we,
  output logic              mem_alu,
  input  logic [DATA_W-1:0] rwdata,
  output logic              busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  cmd_t              cmd_q, cmd_d;
  logic              re_q, re_d, we_q, we_d;
  logic              f_ack_q, f_ack_d, f_err_q, f_err_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic   f_elig_c, d_elig_c, pick_valid_c, grant_c;
  owner_e win_c;

  // The port being acknowledged cannot re-arbitrate in its own ACK cycle
  assign f_elig_c = f_req & ~((state_q == ACK) & (owner_q == OWN_F));
  assign d_elig_c = d_req & ~((state_q == ACK) & (owner_q == OWN_D));

  // owner_q doubles as the last-owner record: it changes on every grant
  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last_i  (owner_q),
`endif
    .f_req_i (f_elig_c),
    .d_req_i (d_elig_c),
    .valid_c (pick_valid_c),
    .owner_c (win_c)
  );

  assign grant_c = pick_valid_c & ((state_q == IDLE) | (state_q == ACK));

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_D;
      cmd_q     <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      f_ack_q   <= 1'b0;
      f_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      re_q      <= re_d;
      we_q      <= we_d;
      f_ack_q   <= f_ack_d;
      f_err_q   <= f_err_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, command latch and ack/read-data generation
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    re_d      = 1'b0;
    we_d      = 1'b0;
    f_ack_d   = 1'b0;
    f_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_c) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = ACK;
        if (owner_q == OWN_F) begin
          f_ack_d = 1'b1;
          f_err_d = cmd_q.mis;
          if (!cmd_q.we) f_rdata_d = rwdata;
        end else begin
          d_ack_d = 1'b1;
          d_err_d = cmd_q.mis;
          if (!cmd_q.we) d_rdata_d = rwdata;
        end
      end
      ACK: begin
        state_d = grant_c ? ACCESS : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Inputs are only sampled here; the strobes follow the latched command
    if (grant_c) begin
      owner_d = win_c;
      if (win_c == OWN_D) begin
        cmd_d.addr  = word_addr(d_addr);
        cmd_d.wdata = d_wdata;
        cmd_d.we    = d_we;
        cmd_d.mis   = d_addr[0];
      end else begin
        cmd_d.addr  = word_addr(f_addr);
        cmd_d.we    = 1'b0;
        cmd_d.mis   = f_addr[0];
      end
      re_d = ~cmd_d.we;
      we_d = cmd_d.we;
    end

    busy_d = (state_d != IDLE);
  end

  assign addrm   = cmd_q.addr;
  assign wmdata  = cmd_q.wdata;
  assign re      = re_q;
  assign we      = we_q;
  assign mem_alu = 1'b0;
  assign f_ack   = f_ack_q;
  assign f_err   = f_err_q;
  assign f_rdata = f_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A byte-array memory answers the DUT;
// a separate transaction-level reference memory predicts read data.
module tb_mem_arbiter;

  logic        clock, reset_n;
  logic        f_req, f_ack, f_err;
  logic [15:0] f_addr, f_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic [15:0] addrm, wmdata, rwdata;
  logic        re, we, mem_alu, busy;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  int tests, fails, cyc;
  bit last_own;  // 1 = data port granted last

  mem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .addrm(addrm), .wmdata(wmdata), .re(re), .we(we), .mem_alu(mem_alu),
    .rwdata(rwdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory block: raw word read, write committed on the edge ending ACCESS
  assign rwdata = {mem[{addrm[15:1], 1'b1}], mem[addrm]};
  always @(posedge clock) begin
    if (we) begin
      mem[addrm]                 = wmdata[7:0];
      mem[{addrm[15:1], 1'b1}]   = wmdata[15:8];
    end
  end

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    logic [15:0] w;
    w = {a[15:1], 1'b0};
    return {ref_mem[{w[15:1], 1'b1}], ref_mem[w]};
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [15:0] v);
    ref_mem[{a[15:1], 1'b0}] = v[7:0];
    ref_mem[{a[15:1], 1'b1}] = v[15:8];
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] b);
    mem[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One isolated access on one port; expected behaviour from the port rules
  task automatic do_txn(input string tag, input bit is_d, input bit wr,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        output int ack_cyc);
    logic [15:0] wa, exp_rd, got_rd;
    bit got_err;
    wa = {addr[15:1], 1'b0};
    if (is_d) begin
      d_req = 1'b1; d_we = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    step();
    tests++;
    if ({re, we} !== {!wr, wr}) begin
      fails++; $display("FAIL %s strobe: re,we=%b expected %b", tag, {re, we}, {!wr, wr});
    end
    tests++;
    if (addrm !== wa) begin
      fails++; $display("FAIL %s addrm: got %h expected %h", tag, addrm, wa);
    end
    if (wr) begin
      tests++;
      if (wmdata !== wdata) begin
        fails++; $display("FAIL %s wmdata: got %h expected %h", tag, wmdata, wdata);
      end
    end
    tests++;
    if ({f_ack, d_ack, busy} !== 3'b001) begin
      fails++; $display("FAIL %s access cycle: f_ack,d_ack,busy=%b expected 001", tag, {f_ack, d_ack, busy});
    end
    // Post-grant input changes must not matter
    f_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom);
    step();
    exp_rd  = ref_word(wa);
    got_rd  = is_d ? d_rdata : f_rdata;
    got_err = is_d ? d_err : f_err;
    tests++;
    if ({f_ack, d_ack} !== {!is_d, is_d}) begin
      fails++; $display("FAIL %s ack: f_ack,d_ack=%b expected %b", tag, {f_ack, d_ack}, {!is_d, is_d});
    end
    tests++;
    if (got_err !== addr[0]) begin
      fails++; $display("FAIL %s err: got %b expected %b", tag, got_err, addr[0]);
    end
    tests++;
    if ({re, we} !== 2'b00) begin
      fails++; $display("FAIL %s strobe after access: re,we=%b expected 00", tag, {re, we});
    end
    if (!wr) begin
      tests++;
      if (got_rd !== exp_rd) begin
        fails++; $display("FAIL %s rdata: got %h expected %h", tag, got_rd, exp_rd);
      end
    end
    ack_cyc = cyc;
    if (wr) ref_write(wa, wdata);
    last_own = is_d;
    f_req = 1'b0; d_req = 1'b0;
    step();
    tests++;
    if ({f_ack, d_ack, busy, re, we} !== 5'b0) begin
      fails++; $display("FAIL %s return to idle: f_ack,d_ack,busy,re,we=%b expected 00000", tag, {f_ack, d_ack, busy, re, we});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) step();
    tests++;
    if ({f_ack, d_ack, f_err, d_err, re, we, busy, mem_alu} !== 8'b0) begin
      fails++; $display("FAIL reset flags: got %b expected 00000000", {f_ack, d_ack, f_err, d_err, re, we, busy, mem_alu});
    end
    tests++;
    if ({addrm, wmdata, f_rdata, d_rdata} !== 64'b0) begin
      fails++; $display("FAIL reset buses: got %h expected 0", {addrm, wmdata, f_rdata, d_rdata});
    end
    reset_n = 1'b1;
    last_own = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    int c;
    poke(16'h0010, 8'h34);
    poke(16'h0011, 8'h12);
    do_txn("fetch_0010", 1'b0, 1'b0, 16'h0010, 16'h0000, c);
    tests++;
    if (f_rdata !== 16'h1234) begin
      fails++; $display("FAIL fetch_0010 hold: f_rdata=%h expected 1234", f_rdata);
    end
    tests++;
    if (mem_alu !== 1'b0) begin
      fails++; $display("FAIL mem_alu: got %b expected 0", mem_alu);
    end
  endtask

  task automatic test_write_read();
    int c1, c2;
    do_txn("wr_0100", 1'b1, 1'b1, 16'h0100, 16'hBEEF, c1);
    do_txn("rd_0100", 1'b1, 1'b0, 16'h0100, 16'h0000, c2);
    tests++;
    if (d_rdata !== 16'hBEEF) begin
      fails++; $display("FAIL readback: d_rdata=%h expected beef", d_rdata);
    end
    tests++;
    if (c2 - c1 !== 3) begin
      fails++; $display("FAIL same-port spacing: %0d cycles expected 3", c2 - c1);
    end
  endtask

  task automatic test_misaligned();
    int c;
    do_txn("misaligned_0101", 1'b1, 1'b0, 16'h0101, 16'h0000, c);
  endtask

  // Both ports request in IDLE; order from the configured arbitration rule
  task automatic test_contention();
    for (int k = 0; k < 6; k++) begin
      logic [15:0] fa, da, dw, exp_rd, got_rd;
      bit dwe, first_d;
      int c1, c2;
      fa  = 16'h0400 + 16'($urandom_range(0, 31));
      da  = 16'h0400 + 16'($urandom_range(0, 31));
      dw  = 16'($urandom);
      dwe = 1'($urandom);
`ifdef MEM_ARB_RR_EN
      first_d = !last_own;
`else
      first_d = 1'b1;
`endif
      f_req = 1'b1; f_addr = fa;
      d_req = 1'b1; d_addr = da; d_we = dwe; d_wdata = dw;
      step();
      tests++;
      if (addrm !== {(first_d ? da[15:1] : fa[15:1]), 1'b0}) begin
        fails++; $display("FAIL contention[%0d] first addrm: got %h (first_d=%b)", k, addrm, first_d);
      end
      step();
      tests++;
      if ({f_ack, d_ack} !== {!first_d, first_d}) begin
        fails++; $display("FAIL contention[%0d] first ack: f_ack,d_ack=%b expected %b", k, {f_ack, d_ack}, {!first_d, first_d});
      end
      c1 = cyc;
      exp_rd = ref_word(first_d ? da : fa);
      got_rd = first_d ? d_rdata : f_rdata;
      if (!(first_d && dwe)) begin
        tests++;
        if (got_rd !== exp_rd) begin
          fails++; $display("FAIL contention[%0d] first rdata: got %h expected %h", k, got_rd, exp_rd);
        end
      end
      if (first_d && dwe) ref_write(da, dw);
      if (first_d) d_req = 1'b0; else f_req = 1'b0;
      step();
      tests++;
      if ({busy, re, we} !== {1'b1, !(!first_d && dwe), !first_d && dwe} || addrm !== {(first_d ? fa[15:1] : da[15:1]), 1'b0}) begin
        fails++; $display("FAIL contention[%0d] second access: busy,re,we=%b addrm=%h", k, {busy, re, we}, addrm);
      end
      step();
      tests++;
      if ({f_ack, d_ack} !== {first_d, !first_d}) begin
        fails++; $display("FAIL contention[%0d] second ack: f_ack,d_ack=%b expected %b", k, {f_ack, d_ack}, {first_d, !first_d});
      end
      c2 = cyc;
      tests++;
      if (c2 - c1 !== 2) begin
        fails++; $display("FAIL contention[%0d] spacing: %0d cycles expected 2", k, c2 - c1);
      end
      exp_rd = ref_word(first_d ? fa : da);
      got_rd = first_d ? f_rdata : d_rdata;
      if (first_d || !dwe) begin
        tests++;
        if (got_rd !== exp_rd) begin
          fails++; $display("FAIL contention[%0d] second rdata: got %h expected %h", k, got_rd, exp_rd);
        end
      end
      if (!first_d && dwe) ref_write(da, dw);
      last_own = !first_d;
      f_req = 1'b0; d_req = 1'b0;
      step();
      tests++;
      if (busy !== 1'b0) begin
        fails++; $display("FAIL contention[%0d] idle: busy=%b expected 0", k, busy);
      end
    end
  endtask

  task automatic test_early_drop();
    logic [15:0] exp_rd;
    f_req = 1'b1; f_addr = 16'h0042;
    exp_rd = ref_word(16'h0042);
    step();
    f_req = 1'b0;
    step();
    tests++;
    if (f_ack !== 1'b1 || f_rdata !== exp_rd) begin
      fails++; $display("FAIL early_drop ack: f_ack=%b f_rdata=%h expected 1 %h", f_ack, f_rdata, exp_rd);
    end
    last_own = 1'b0;
    step();
    tests++;
    if ({busy, f_ack} !== 2'b00) begin
      fails++; $display("FAIL early_drop idle: busy,f_ack=%b expected 00", {busy, f_ack});
    end
  endtask

  task automatic test_reset_mid();
    poke(16'h0200, 8'hAA);
    poke(16'h0201, 8'h00);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h5555;
    step();
    tests++;
    if (we !== 1'b1) begin
      fails++; $display("FAIL reset_mid write strobe: we=%b expected 1", we);
    end
    #2;
    reset_n = 1'b0;
    d_req = 1'b0;
    #1;
    tests++;
    if ({f_ack, d_ack, f_err, d_err, re, we, busy, addrm, wmdata, f_rdata, d_rdata} !== 71'b0) begin
      fails++; $display("FAIL reset_mid outputs: we=%b busy=%b addrm=%h wmdata=%h", we, busy, addrm, wmdata);
    end
    repeat (2) step();
    tests++;
    if ({mem[16'h0201], mem[16'h0200]} !== ref_word(16'h0200)) begin
      fails++; $display("FAIL reset_mid memory: got %h expected %h", {mem[16'h0201], mem[16'h0200]}, ref_word(16'h0200));
    end
    reset_n = 1'b1;
    last_own = 1'b1;
    step();
    tests++;
    if ({d_ack, busy} !== 2'b00) begin
      fails++; $display("FAIL reset_mid after release: d_ack,busy=%b expected 00", {d_ack, busy});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      bit is_d, wr;
      logic [15:0] a;
      int c;
      is_d = 1'($urandom);
      wr   = is_d ? 1'($urandom) : 1'b0;
      a    = 16'h0300 + 16'($urandom_range(0, 63));
      do_txn("random", is_d, wr, a, 16'($urandom), c);
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; last_own = 1'b1;
    reset_n = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    test_reset();
    test_single_fetch();
    test_write_read();
    test_contention();
    test_misaligned();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared 16-bit byte-addressed program/data memory. Accepts word accesses from the instruction-fetch port (read-only) and the data port (read/write). Grants one access at a time, registers and drives the memory command for exactly one cycle, and returns read data with a one-cycle acknowledge. Sits between the core's fetch/load-store units and the memory block.

## Interface
- ADDR_W, 16, address width (byte address)
- DATA_W, 16, word width; two bytes per word, low byte at the even address
- clock  in  1  system clock, all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request; held high until f_ack
- f_addr  in  ADDR_W  fetch byte address
- f_ack  out  1  one-cycle pulse: fetch complete, f_rdata valid
- f_rdata  out  DATA_W  fetch read data; holds value until the next fetch ack
- f_err  out  1  pulses with f_ack if f_addr[0] was 1
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  data read data, valid with d_ack on reads; holds otherwise
- d_err  out  1  pulses with d_ack if d_addr[0] was 1
- addrm  out  ADDR_W  memory address, bit 0 always 0
- wmdata  out  DATA_W  memory write data
- re  out  1  memory read strobe
- we  out  1  memory write strobe
- mem_alu  out  1  constant 0 (raw read path selected)
- rwdata  in  DATA_W  memory raw read word
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCESS, ACK. Reset to IDLE.
- IDLE: if any request is pending, select a winner, latch its address (bit 0 cleared), we and wdata into command registers, latch the misalign flag, record the owner, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: addrm/wmdata come from the command registers. re = !cmd_we and we = cmd_we, both high for this cycle only. On the ending edge, the memory commits a write. On a read, rwdata is captured into the owner's rdata register. Next state is ACK.
- ACK: the owner's ack is high, and its err is high if misaligned. The owner's req is ignored for arbitration in this cycle. If the other port requests, grant it directly into ACCESS. Otherwise go to IDLE.
- Arbitration, with both requesting: see Configuration. With one requesting, that port wins.
- Inputs are sampled only on the grant edge. Changes after the grant are ignored.
- If a requester drops req before its ack, the access still completes and the ack still pulses.
- A fetch never writes: cmd_we is forced 0 for the fetch owner.
- Reset values: f_ack = d_ack = f_err = d_err = re = we = busy = 0; addrm = wmdata = f_rdata = d_rdata = 0; mem_alu = 0.
- Asserting reset_n low mid-access aborts immediately and clears all outputs. A write in ACCESS that has not reached its edge is not performed.

## Timing
- Grant edge E0 (req seen in IDLE). ACCESS during cycle E0–E1. Ack during cycle E1–E2. Latency is 2 cycles from the sampling edge to the ack cycle.
- Back-to-back, alternating ports: one access per 2 cycles (ACK→ACCESS).
- Same port repeatedly: one access per 3 cycles, because of one IDLE cycle between accesses.
- All outputs are registered. There are no combinational paths from req inputs to memory outputs.

## Configuration
- MEM_ARB_RR_EN defined: round-robin.
  - A last-owner register resets to "data", so the first contended grant goes to fetch.
  - On contention, the port not granted last wins. The register updates on every grant.
- Not defined: fixed priority, data port always wins on contention. No last-owner register.

## Structure
- Shared package: state encoding (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2), owner encoding (OWN_F=1'b0, OWN_D=1'b1), ADDR_W/DATA_W defaults.
- One natural sub-module, mem_arb_pick: a two-requester winner select. It is round-robin or fixed depending on MEM_ARB_RR_EN, with the last-owner state held in the parent.

## Test plan
- Reset, single fetch: reset_n low then high, mem[0x0010..0x0011] = 0x34,0x12.
  - Stimulus: f_req with f_addr = 0x0010.
  - Response: re high for one cycle with addrm = 0x0010, then f_ack with f_rdata = 0x1234, f_err = 0, we never high.
- Data write then read back: d_we = 1, d_addr = 0x0100, d_wdata = 0xBEEF.
  - Response: we high for one cycle, wmdata = 0xBEEF, d_ack.
  - Then d_we = 0, same address: d_ack with d_rdata = 0xBEEF, 3 cycles after the previous ack.
- Contention: f_req and d_req high together in IDLE.
  - With MEM_ARB_RR_EN: fetch is acked first, then data at the next ACK→ACCESS, 2 cycles apart.
  - Without MEM_ARB_RR_EN: data first.
- Misaligned: d_addr = 0x0101, read.
  - Response: addrm = 0x0100, d_ack and d_err pulse together, d_rdata = word at 0x0100.
- Early drop: f_req high for 1 cycle only.
  - Response: f_ack still pulses 2 cycles later, then the block returns to IDLE with busy = 0.
- Reset mid-access: reset_n low during ACCESS of a write 0x5555 to 0x0200.
  - Response: we drops to 0 immediately, no ack, memory word unchanged, all outputs 0.
